// File: rtl/de10lite_qsys_onchip_ram_dp_if.sv
// Avalon-MM slave port bundle for the dual-port on-chip RAM: one instance per port (s1, s2).
// The master modport is the interconnect/bench side; the slave modport is the RAM side.
interface de10lite_qsys_onchip_ram_dp_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 13
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/de10lite_qsys_onchip_ram_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, byte enables and pipelined reads.
// Optional macro ONCHIP_RAM_RDW_BYPASS_EN: mixed-port read-during-write returns new data.
module de10lite_qsys_onchip_ram_dp #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 13,
   parameter int READ_LAT  = 2,
   parameter     INIT_FILE = ""
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clken,
   input  logic reset_req,
   input  logic freeze,
   de10lite_qsys_onchip_ram_dp_if.slave s1,
   de10lite_qsys_onchip_ram_dp_if.slave s2
);
   localparam int BE_W  = DATA_W / 8;
   localparam int NPORT = 2;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] word_t;

   (* ram_init_file = INIT_FILE *) word_t mem [DEPTH];

   // Port 0 is s1, port 1 is s2 throughout.
   logic [ADDR_W-1:0] addr   [NPORT];
   logic [BE_W-1:0]   be     [NPORT];
   word_t             wdata  [NPORT];
   logic              cs     [NPORT];
   logic              req_rd [NPORT];
   logic              req_wr [NPORT];

   assign addr[0]   = s1.address;
   assign addr[1]   = s2.address;
   assign be[0]     = s1.byteenable;
   assign be[1]     = s2.byteenable;
   assign wdata[0]  = s1.writedata;
   assign wdata[1]  = s2.writedata;
   assign cs[0]     = s1.chipselect;
   assign cs[1]     = s2.chipselect;
   assign req_rd[0] = s1.read;
   assign req_rd[1] = s2.read;
   assign req_wr[0] = s1.write;
   assign req_wr[1] = s2.write;

   logic wait_req;
   logic rd_acc [NPORT];
   logic wr_en  [NPORT];

   assign wait_req = ~clken | reset_req;

   // A read with write also high is a write; frozen writes are accepted but have no effect.
   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         rd_acc[p] = cs[p] & req_rd[p] & ~req_wr[p] & ~wait_req;
         wr_en[p]  = cs[p] & req_wr[p] & ~wait_req & ~freeze;
      end
   end

   // NOTE: the array has no reset branch; clearing it would prevent block-RAM inference
   // and its contents are defined only by configuration and writes.
   always_ff @(posedge clk) begin
      // s2 is applied first so that s1's later assignment wins on a shared byte.
      for (int p = NPORT - 1; p >= 0; p--) begin
         if (wr_en[p]) begin
            for (int b = 0; b < BE_W; b++) begin
               if (be[p][b]) mem[addr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
            end
         end
      end
   end

   word_t rd_word [NPORT];

   // NOTE: combinational blocks use blocking assignments and assign every output first,
   // so the later byte overrides see the defaulted value and no latch is inferred.
   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         rd_word[p] = mem[addr[p]];
      end
`ifdef ONCHIP_RAM_RDW_BYPASS_EN
      // A reading port is never writing, so only the other port's bytes can overlay.
      for (int p = 0; p < NPORT; p++) begin
         if (wr_en[1-p] && (addr[1-p] == addr[p])) begin
            for (int b = 0; b < BE_W; b++) begin
               if (be[1-p][b]) rd_word[p][8*b +: 8] = wdata[1-p][8*b +: 8];
            end
         end
      end
`endif
   end

   logic [READ_LAT-1:0] vld_q  [NPORT];
   word_t               data_q [NPORT][READ_LAT];

   // The pipeline advances every clock regardless of clken/reset_req so that
   // in-flight reads always drain; only new accepts are gated.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < NPORT; p++) begin
            vld_q[p] <= '0;
            for (int s = 0; s < READ_LAT; s++) data_q[p][s] <= '0;
         end
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            vld_q[p][0] <= rd_acc[p];
            if (rd_acc[p]) data_q[p][0] <= rd_word[p];
            for (int s = 1; s < READ_LAT; s++) begin
               vld_q[p][s]  <= vld_q[p][s-1];
               data_q[p][s] <= data_q[p][s-1];
            end
         end
      end
   end

   assign s1.waitrequest   = wait_req;
   assign s2.waitrequest   = wait_req;
   assign s1.readdata      = data_q[0][READ_LAT-1];
   assign s2.readdata      = data_q[1][READ_LAT-1];
   assign s1.readdatavalid = vld_q[0][READ_LAT-1];
   assign s2.readdatavalid = vld_q[1][READ_LAT-1];
endmodule

// File: tb/tb_de10lite_qsys_onchip_ram_dp.sv
// Directed bench for the dual-port on-chip RAM; expected words are hand-computed.
// Build with +define+ONCHIP_RAM_RDW_BYPASS_EN to check the bypass variant.
module tb_de10lite_qsys_onchip_ram_dp;
   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 13;
   localparam int READ_LAT = 2;
   localparam int BE_W     = DATA_W / 8;
`ifdef ONCHIP_RAM_RDW_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef logic [DATA_W-1:0] word_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clken = 1'b1;
   logic reset_req = 1'b0;
   logic freeze = 1'b0;

   int pass_cnt = 0;
   int check_cnt = 0;

   always #5 clk = ~clk;

   de10lite_qsys_onchip_ram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s1_bus ();
   de10lite_qsys_onchip_ram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s2_bus ();

   de10lite_qsys_onchip_ram_dp #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .INIT_FILE("")
   ) dut (
      .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
      .freeze(freeze), .s1(s1_bus), .s2(s2_bus)
   );

   function automatic logic port_vld(input int p);
      return (p == 1) ? s1_bus.readdatavalid : s2_bus.readdatavalid;
   endfunction

   function automatic word_t port_rdata(input int p);
      return (p == 1) ? s1_bus.readdata : s2_bus.readdata;
   endfunction

   task automatic clear_bus();
      s1_bus.chipselect = 1'b0; s1_bus.read = 1'b0; s1_bus.write = 1'b0;
      s1_bus.address = '0; s1_bus.byteenable = '0; s1_bus.writedata = '0;
      s2_bus.chipselect = 1'b0; s2_bus.read = 1'b0; s2_bus.write = 1'b0;
      s2_bus.address = '0; s2_bus.byteenable = '0; s2_bus.writedata = '0;
   endtask

   task automatic set_op(input int p, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input word_t d, input logic [BE_W-1:0] b);
      if (p == 1) begin
         s1_bus.chipselect = 1'b1; s1_bus.read = rd; s1_bus.write = wr;
         s1_bus.address = a; s1_bus.writedata = d; s1_bus.byteenable = b;
      end else begin
         s2_bus.chipselect = 1'b1; s2_bus.read = rd; s2_bus.write = wr;
         s2_bus.address = a; s2_bus.writedata = d; s2_bus.byteenable = b;
      end
   endtask

   // All stimulus tasks start and end on a falling edge with the buses idle.
   task automatic write_word(input int p, input logic [ADDR_W-1:0] a, input word_t d,
                             input logic [BE_W-1:0] b);
      set_op(p, 1'b0, 1'b1, a, d, b);
      @(negedge clk);
      clear_bus();
   endtask

   task automatic wait_valid(input int p, output word_t d, output bit got);
      got = 1'b0;
      d = '0;
      for (int i = 0; i < 8 && !got; i++) begin
         if (port_vld(p) === 1'b1) begin
            d = port_rdata(p);
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic read_word(input int p, input logic [ADDR_W-1:0] a, output word_t d,
                            output bit got);
      set_op(p, 1'b1, 1'b0, a, '0, '0);
      @(negedge clk);
      clear_bus();
      wait_valid(p, d, got);
   endtask

   task automatic test_reset();
      clear_bus();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_cnt++;
      if ({s1_bus.readdatavalid, s2_bus.readdatavalid} !== 2'b00)
         $display("FAIL reset_valid: got %b expected 00", {s1_bus.readdatavalid, s2_bus.readdatavalid});
      else pass_cnt++;
      check_cnt++;
      if ((s1_bus.readdata | s2_bus.readdata) !== '0)
         $display("FAIL reset_rdata: got %h/%h expected 0", s1_bus.readdata, s2_bus.readdata);
      else pass_cnt++;
      reset_n = 1'b1;
      @(negedge clk);
      check_cnt++;
      if ({s1_bus.waitrequest, s2_bus.waitrequest} !== 2'b00)
         $display("FAIL wait_idle: got %b expected 00", {s1_bus.waitrequest, s2_bus.waitrequest});
      else pass_cnt++;
      clken = 1'b0;
      #1;
      check_cnt++;
      if ({s1_bus.waitrequest, s2_bus.waitrequest} !== 2'b11)
         $display("FAIL wait_clken: got %b expected 11", {s1_bus.waitrequest, s2_bus.waitrequest});
      else pass_cnt++;
      clken = 1'b1;
      reset_req = 1'b1;
      #1;
      check_cnt++;
      if ({s1_bus.waitrequest, s2_bus.waitrequest} !== 2'b11)
         $display("FAIL wait_reset_req: got %b expected 11", {s1_bus.waitrequest, s2_bus.waitrequest});
      else pass_cnt++;
      reset_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_latency();
      write_word(1, 5, 64'h1122_3344_5566_7788, 8'hFF);
      set_op(1, 1'b1, 1'b0, 5, '0, '0);
      for (int cyc = 1; cyc <= READ_LAT + 1; cyc++) begin
         @(negedge clk);
         if (cyc == 1) clear_bus();
         check_cnt++;
         if (s1_bus.readdatavalid !== (cyc == READ_LAT))
            $display("FAIL latency_valid_c%0d: got %b expected %b", cyc, s1_bus.readdatavalid, (cyc == READ_LAT));
         else pass_cnt++;
         if (cyc == READ_LAT) begin
            check_cnt++;
            if (s1_bus.readdata !== 64'h1122_3344_5566_7788)
               $display("FAIL latency_data: got %h expected 1122334455667788", s1_bus.readdata);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_byteenable();
      word_t d;
      bit got;
      write_word(2, 9, 64'h0123_4567_89AB_CDEF, 8'hFF);
      write_word(2, 9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      read_word(1, 9, d, got);
      check_cnt++;
      if (!got || d !== 64'h0123_4567_FFFF_FFFF)
         $display("FAIL byteenable: got %h (valid %b) expected 01234567ffffffff", d, got);
      else pass_cnt++;
   endtask

   task automatic test_collision();
      word_t d;
      bit got;
      set_op(1, 1'b0, 1'b1, 3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0);
      set_op(2, 1'b0, 1'b1, 3, 64'h5555_5555_5555_5555, 8'hFF);
      @(negedge clk);
      clear_bus();
      read_word(2, 3, d, got);
      check_cnt++;
      if (!got || d !== 64'hAAAA_AAAA_5555_5555)
         $display("FAIL collision_full: got %h (valid %b) expected aaaaaaaa55555555", d, got);
      else pass_cnt++;
      write_word(1, 3, 64'h1111_1111_1111_1111, 8'hFF);
      set_op(1, 1'b0, 1'b1, 3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
      set_op(2, 1'b0, 1'b1, 3, 64'h5555_5555_5555_5555, 8'h3C);
      @(negedge clk);
      clear_bus();
      read_word(1, 3, d, got);
      check_cnt++;
      if (!got || d !== 64'h1111_5555_AAAA_AAAA)
         $display("FAIL collision_partial: got %h (valid %b) expected 11115555aaaaaaaa", d, got);
      else pass_cnt++;
   endtask

   task automatic test_rdw();
      word_t d;
      bit got;
      write_word(1, 7, '0, 8'hFF);
      set_op(1, 1'b0, 1'b1, 7, 64'h1234, 8'hFF);
      set_op(2, 1'b1, 1'b0, 7, '0, '0);
      @(negedge clk);
      clear_bus();
      wait_valid(2, d, got);
      check_cnt++;
      if (!got || d !== (BYPASS ? 64'h1234 : 64'h0))
         $display("FAIL rdw_s2_reads: got %h (valid %b) expected %h", d, got, (BYPASS ? 64'h1234 : 64'h0));
      else pass_cnt++;
      set_op(2, 1'b0, 1'b1, 7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
      set_op(1, 1'b1, 1'b0, 7, '0, '0);
      @(negedge clk);
      clear_bus();
      wait_valid(1, d, got);
      check_cnt++;
      if (!got || d !== (BYPASS ? 64'h12FF : 64'h1234))
         $display("FAIL rdw_s1_reads: got %h (valid %b) expected %h", d, got, (BYPASS ? 64'h12FF : 64'h1234));
      else pass_cnt++;
      freeze = 1'b1;
      set_op(1, 1'b0, 1'b1, 7, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
      set_op(2, 1'b1, 1'b0, 7, '0, '0);
      @(negedge clk);
      clear_bus();
      freeze = 1'b0;
      wait_valid(2, d, got);
      check_cnt++;
      if (!got || d !== 64'h12FF)
         $display("FAIL rdw_frozen: got %h (valid %b) expected 12ff", d, got);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      word_t got_q[$];
      word_t d;
      bit got;
      int seen_before_release;
      for (int i = 0; i < 4; i++) write_word(1, i, 64'hC0DE_0000_0000_0000 | i, 8'hFF);
      seen_before_release = 0;
      for (int i = 0; i < 12; i++) begin
         if (s1_bus.readdatavalid === 1'b1) got_q.push_back(s1_bus.readdata);
         if (i == 5) seen_before_release = got_q.size();
         clear_bus();
         clken = 1'b1;
         case (i)
            0:       set_op(1, 1'b1, 1'b0, 0, '0, '0);
            1:       set_op(1, 1'b1, 1'b0, 1, '0, '0);
            2, 3, 4: begin clken = 1'b0; set_op(1, 1'b1, 1'b0, 2, '0, '0); end
            5:       set_op(1, 1'b1, 1'b0, 2, '0, '0);
            6:       set_op(1, 1'b1, 1'b0, 3, '0, '0);
            default: ;
         endcase
         if (i == 2) begin
            #1;
            check_cnt++;
            if (s1_bus.waitrequest !== 1'b1)
               $display("FAIL b2b_stall_wait: got %b expected 1", s1_bus.waitrequest);
            else pass_cnt++;
         end
         @(negedge clk);
      end
      clear_bus();
      check_cnt++;
      if (seen_before_release != 2)
         $display("FAIL b2b_inflight: got %0d returns during stall expected 2", seen_before_release);
      else pass_cnt++;
      check_cnt++;
      if (got_q.size() != 4)
         $display("FAIL b2b_count: got %0d returns expected 4", got_q.size());
      else pass_cnt++;
      for (int i = 0; i < got_q.size() && i < 4; i++) begin
         check_cnt++;
         if (got_q[i] !== (64'hC0DE_0000_0000_0000 | i))
            $display("FAIL b2b_order_%0d: got %h expected %h", i, got_q[i], 64'hC0DE_0000_0000_0000 | i);
         else pass_cnt++;
      end

      // read and write together behave as a write only
      set_op(1, 1'b1, 1'b1, 0, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF);
      @(negedge clk);
      clear_bus();
      got = 1'b0;
      for (int i = 0; i < READ_LAT + 1; i++) begin
         if (s1_bus.readdatavalid === 1'b1) got = 1'b1;
         @(negedge clk);
      end
      check_cnt++;
      if (got !== 1'b0) $display("FAIL rw_no_valid: got valid 1 expected 0");
      else pass_cnt++;
      read_word(2, 0, d, got);
      check_cnt++;
      if (!got || d !== 64'h5A5A_5A5A_5A5A_5A5A)
         $display("FAIL rw_write_done: got %h (valid %b) expected 5a5a5a5a5a5a5a5a", d, got);
      else pass_cnt++;

      write_word(1, 4, 64'h0444_0444_0444_0444, 8'hFF);
      freeze = 1'b1;
      write_word(1, 4, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
      write_word(2, 4, 64'hBAD1_BAD1_BAD1_BAD1, 8'hFF);
      freeze = 1'b0;
      read_word(1, 4, d, got);
      check_cnt++;
      if (!got || d !== 64'h0444_0444_0444_0444)
         $display("FAIL freeze_write: got %h (valid %b) expected 0444044404440444", d, got);
      else pass_cnt++;
   endtask

   task automatic test_reset_inflight();
      word_t d;
      bit got;
      bit saw;
      set_op(2, 1'b1, 1'b0, 5, '0, '0);
      @(negedge clk);
      clear_bus();
      reset_n = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if ((s1_bus.readdatavalid | s2_bus.readdatavalid) !== 1'b0) saw = 1'b1;
         if ((s1_bus.readdata | s2_bus.readdata) !== '0) saw = 1'b1;
         @(negedge clk);
         if (i == 1) reset_n = 1'b1;
      end
      check_cnt++;
      if (saw !== 1'b0) $display("FAIL reset_inflight: got activity 1 expected 0");
      else pass_cnt++;
      read_word(1, 5, d, got);
      check_cnt++;
      if (!got || d !== 64'h1122_3344_5566_7788)
         $display("FAIL mem_kept: got %h (valid %b) expected 1122334455667788", d, got);
      else pass_cnt++;
   endtask

   initial begin
      clear_bus();
      test_reset();
      test_read_latency();
      test_byteenable();
      test_collision();
      test_rdw();
      test_back_to_back();
      test_reset_inflight();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
